addr_dec_resp_mux_varlat_mo: RTL and testbench



---
 rtl/tcdm_varlat_pkg.sv | 19 +
 rtl/tcdm_resp_stage.sv | 42 ++++
 rtl/addr_dec_resp_mux_varlat_mo.sv | 125 ++++++++++++
 tb/tb_addr_dec_resp_mux_varlat_mo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_varlat_pkg.sv
// Shared sizing helpers and bank-index type for the variable-latency TCDM
// crossbar (address decoders and per-bank arbitration trees).
package tcdm_varlat_pkg;

    // Width of a bank index; a single bank still gets a 1-bit index
    function automatic int unsigned addr_width(input int unsigned num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_out inclusive
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned DefaultNumOut = 32;

    typedef logic [addr_width(DefaultNumOut)-1:0] bank_idx_t;

endpackage

// File: rtl/tcdm_resp_stage.sv
// Optional response register between the bank response mux and the master.
// With RespReg=0 the stage is a wire; with RespReg=1 valid is re-timed by one
// cycle and data is captured only on a valid beat so it holds in between.
module tcdm_resp_stage #(
    parameter int unsigned RespDataWidth = 32,
    parameter bit          RespReg       = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     vld_i,
    input  logic [RespDataWidth-1:0] rdata_i,
    output logic                     vld_o,
    output logic [RespDataWidth-1:0] rdata_o
);

    if (RespReg) begin : g_reg
        logic                     vld_q;
        logic [RespDataWidth-1:0] rdata_q;

        // Re-time the response; data loads only with a valid beat
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                vld_q <= vld_i;
                if (vld_i) begin
                    rdata_q <= rdata_i;
                end
            end
        end

        assign vld_o   = vld_q;
        assign rdata_o = rdata_q;
    end else begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign vld_o          = vld_i;
        assign rdata_o        = rdata_i;
    end

endmodule

// File: rtl/addr_dec_resp_mux_varlat_mo.sv
// Per-master address decoder and response mux for the variable-latency TCDM
// crossbar. Up to MaxOutstanding requests may be in flight to one bank; a
// request to a different bank waits until every earlier response has drained,
// which keeps responses in issue order without any reorder buffer.
module addr_dec_resp_mux_varlat_mo
    import tcdm_varlat_pkg::*;
#(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          RespReg        = 1'b0,
    parameter int unsigned AddrWidth      = addr_width(NumOut),
    parameter int unsigned CntWidth       = cnt_width(MaxOutstanding)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_i,
    input  logic [AddrWidth-1:0]                 add_i,
    input  logic                                 wen_i,
    input  logic [ReqDataWidth-1:0]              data_i,
    output logic                                 gnt_o,
    output logic                                 vld_o,
    output logic [RespDataWidth-1:0]             rdata_o,
    output logic [NumOut-1:0]                    req_o,
    output logic [NumOut-1:0]                    wen_o,
    output logic [NumOut-1:0][ReqDataWidth-1:0]  data_o,
    input  logic [NumOut-1:0]                    gnt_i,
    input  logic [NumOut-1:0]                    vld_i,
    input  logic [NumOut-1:0][RespDataWidth-1:0] rdata_i,
    output logic [CntWidth-1:0]                  outstanding_o,
    output logic                                 busy_o,
    output logic                                 spurious_vld_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0]      cnt_q, cnt_d, cnt_eff;
    logic [AddrWidth-1:0]     bank_q, bank_d, add_idx;
    logic [NumOut-1:0]        sel;
    logic                     add_valid, drain, allow, acc, spurious_q;
    logic [RespDataWidth-1:0] resp_data;

    // With one bank the address is meaningless and the block is a credit counter
    if (NumOut == 1) begin : g_single
        logic unused_add;
        assign unused_add = ^add_i;
        assign add_idx    = '0;
        assign add_valid  = 1'b1;
    end else begin : g_multi
        assign add_idx    = add_i;
        assign add_valid  = (32'(add_i) < NumOut);
    end

    // A response from the tracked bank retires one credit this cycle, which
    // lets a full master issue again (or switch bank) in the same cycle.
    assign drain   = (cnt_q != '0) & vld_i[bank_q];
    assign cnt_eff = cnt_q - CntWidth'(drain);
    assign allow   = add_valid &
                     ((cnt_eff == '0) | ((add_idx == bank_q) & (cnt_eff < MaxCnt)));

    // Decode the request to one bank; grant only from the addressed bank
    always_comb begin
        req_o = '0;
        gnt_o = 1'b0;
        if (add_valid) begin
            req_o[add_idx] = req_i & allow;
            gnt_o          = gnt_i[add_idx] & allow;
        end
    end

    assign acc    = req_i & gnt_o;
    assign cnt_d  = cnt_eff + CntWidth'(acc);
    assign bank_d = acc ? add_idx : bank_q;

    // Only the tracked bank may legally respond, and only while something is in flight
    always_comb begin
        sel = '0;
        if (cnt_q != '0) begin
            sel[bank_q] = 1'b1;
        end
    end

    // In-flight tracking and the unexpected-response flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            bank_q     <= '0;
            spurious_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            spurious_q <= |(vld_i & ~sel);
        end
    end

    assign wen_o          = {NumOut{wen_i}};
    assign data_o         = {NumOut{data_i}};
    assign resp_data      = rdata_i[bank_q];
    assign outstanding_o  = cnt_q;
    assign busy_o         = (cnt_q != '0);
    assign spurious_vld_o = spurious_q;

    tcdm_resp_stage #(
        .RespDataWidth (RespDataWidth),
        .RespReg       (RespReg)
    ) i_resp_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .vld_i   (drain),
        .rdata_i (resp_data),
        .vld_o   (vld_o),
        .rdata_o (rdata_o)
    );

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i) (NumOut > 0) && (MaxOutstanding > 0))
        else $error("NumOut and MaxOutstanding must be non-zero");
    a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= MaxCnt)
        else $error("outstanding counter out of range");
    a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) gnt_o |-> req_i)
        else $error("grant without request");
`endif

endmodule

// File: tb/tb_addr_dec_resp_mux_varlat_mo.sv
// Bench for addr_dec_resp_mux_varlat_mo: two instances (combinational and
// registered response path) share all inputs; a slave model grants every
// decoded request and echoes the request payload after a programmable latency.
module tb_addr_dec_resp_mux_varlat_mo;

    localparam int NumOut = 4;
    localparam int DW     = 32;
    localparam int MO     = 4;
    localparam int AW     = 2;
    localparam int CW     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_i, req_i, wen_i;
    logic [AW-1:0]              add_i;
    logic [DW-1:0]              data_i;
    logic [NumOut-1:0]          gnt_i, vld_i;
    logic [NumOut-1:0][DW-1:0]  rdata_i;

    logic                       gnt0, vld0, busy0, spur0;
    logic [DW-1:0]              rdata0;
    logic [NumOut-1:0]          req_o0, wen_o0;
    logic [NumOut-1:0][DW-1:0]  data_o0;
    logic [CW-1:0]              out0;

    logic                       gnt1, vld1, busy1, spur1;
    logic [DW-1:0]              rdata1;
    logic [NumOut-1:0]          req_o1, wen_o1;
    logic [NumOut-1:0][DW-1:0]  data_o1;
    logic [CW-1:0]              out1;

    assign gnt_i = req_o0;

    addr_dec_resp_mux_varlat_mo #(
        .NumOut(NumOut), .ReqDataWidth(DW), .RespDataWidth(DW),
        .MaxOutstanding(MO), .RespReg(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .data_i(data_i), .gnt_o(gnt0), .vld_o(vld0), .rdata_o(rdata0),
        .req_o(req_o0), .wen_o(wen_o0), .data_o(data_o0), .gnt_i(gnt_i),
        .vld_i(vld_i), .rdata_i(rdata_i), .outstanding_o(out0), .busy_o(busy0),
        .spurious_vld_o(spur0)
    );

    addr_dec_resp_mux_varlat_mo #(
        .NumOut(NumOut), .ReqDataWidth(DW), .RespDataWidth(DW),
        .MaxOutstanding(MO), .RespReg(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .data_i(data_i), .gnt_o(gnt1), .vld_o(vld1), .rdata_o(rdata1),
        .req_o(req_o1), .wen_o(wen_o1), .data_o(data_o1), .gnt_i(gnt_i),
        .vld_i(vld_i), .rdata_i(rdata_i), .outstanding_o(out1), .busy_o(busy1),
        .spurious_vld_o(spur1)
    );

    typedef struct {
        int          due;
        int          bank;
        logic [31:0] data;
        bit          legit;
    } rsp_t;

    rsp_t        slv_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int model_out = 0;
    int max_out = 0;
    bit mon_en = 1'b0;
    bit legit_now = 1'b0;
    bit illegit_now = 1'b0;
    bit spur_exp = 1'b0;
    bit legit_prev = 1'b0;
    bit inj_en = 1'b0;
    int inj_bank = 0;

    bit          obs_gnt, obs_vld, obs_spur, obs_busy, obs_vld1;
    logic [3:0]  obs_req;
    logic [31:0] obs_rdata1;
    int          obs_out, obs_cyc;

    // One clock cycle: monitor/scoreboard at the falling edge, slave drive after the rising edge
    task automatic cycle();
        bit          nspur, nlegit;
        logic [31:0] d;
        rsp_t        e;
        int          idx;
        @(negedge clk);
        obs_cyc = cyc; obs_gnt = gnt0; obs_req = req_o0; obs_vld = vld0;
        obs_spur = spur0; obs_busy = busy0; obs_out = int'(out0);
        obs_vld1 = vld1; obs_rdata1 = rdata1;
        if (mon_en) begin
            checks++;
            if (out0 !== CW'(model_out)) begin
                failures++; $display("FAIL outstanding cyc=%0d got=%0d want=%0d", cyc, out0, model_out);
            end
            checks++;
            if (busy0 !== (model_out != 0)) begin
                failures++; $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, busy0, (model_out != 0));
            end
            checks++;
            if (vld0 !== legit_now) begin
                failures++; $display("FAIL vld_comb cyc=%0d got=%0b want=%0b", cyc, vld0, legit_now);
            end
            checks++;
            if (vld1 !== legit_prev) begin
                failures++; $display("FAIL vld_reg cyc=%0d got=%0b want=%0b", cyc, vld1, legit_prev);
            end
            checks++;
            if (spur0 !== spur_exp || spur1 !== spur_exp) begin
                failures++; $display("FAIL spurious cyc=%0d got=%0b/%0b want=%0b", cyc, spur0, spur1, spur_exp);
            end
            if (obs_out > max_out) max_out = obs_out;
        end
        if (legit_now) begin
            checks++;
            if (exp0_q.size() == 0) begin
                failures++; $display("FAIL sb_comb_empty cyc=%0d got=response want=none", cyc);
            end else begin
                d = exp0_q.pop_front();
                if (rdata0 !== d) begin
                    failures++; $display("FAIL rdata_comb cyc=%0d got=%h want=%h", cyc, rdata0, d);
                end
                exp1_q.push_back(d);
            end
        end
        if (legit_prev) begin
            checks++;
            if (exp1_q.size() == 0) begin
                failures++; $display("FAIL sb_reg_empty cyc=%0d got=response want=none", cyc);
            end else begin
                d = exp1_q.pop_front();
                if (rdata1 !== d) begin
                    failures++; $display("FAIL rdata_reg cyc=%0d got=%h want=%h", cyc, rdata1, d);
                end
            end
        end
        if (rst_i) begin
            model_out = 0;
            exp0_q.delete();
            exp1_q.delete();
            foreach (slv_q[i]) slv_q[i].legit = 1'b0;
            nspur = 1'b0;
            nlegit = 1'b0;
        end else begin
            if (legit_now) model_out--;
            if (req_i && gnt0) begin
                e.due = cyc + lat; e.bank = int'(add_i); e.data = data_i; e.legit = 1'b1;
                slv_q.push_back(e);
                exp0_q.push_back(data_i);
                model_out++;
            end
            nspur = illegit_now;
            nlegit = legit_now;
        end
        @(posedge clk);
        #1;
        cyc++;
        spur_exp = nspur;
        legit_prev = nlegit;
        vld_i = '0;
        legit_now = 1'b0;
        illegit_now = 1'b0;
        for (int b = 0; b < NumOut; b++) rdata_i[b] = $urandom;
        idx = 0;
        while (idx < slv_q.size()) begin
            if (slv_q[idx].due == cyc) begin
                vld_i[slv_q[idx].bank] = 1'b1;
                rdata_i[slv_q[idx].bank] = slv_q[idx].data;
                if (slv_q[idx].legit) legit_now = 1'b1;
                else illegit_now = 1'b1;
                slv_q.delete(idx);
            end else begin
                idx++;
            end
        end
        if (inj_en) begin
            vld_i[inj_bank] = 1'b1;
            illegit_now = 1'b1;
            inj_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; wen_i = 1'b0; add_i = '0; data_i = '0;
        vld_i = '0; rdata_i = '0; mon_en = 1'b0;
        cycle();
        cycle();
        rst_i = 1'b0;
        checks++;
        if (out0 !== '0 || busy0 !== 1'b0) begin
            failures++; $display("FAIL reset_count got=%0d/%0b want=0/0", out0, busy0);
        end
        checks++;
        if (vld0 !== 1'b0 || vld1 !== 1'b0) begin
            failures++; $display("FAIL reset_vld got=%0b/%0b want=0/0", vld0, vld1);
        end
        checks++;
        if (rdata1 !== '0) begin
            failures++; $display("FAIL reset_rdata got=%h want=0", rdata1);
        end
        checks++;
        if (spur0 !== 1'b0 || spur1 !== 1'b0) begin
            failures++; $display("FAIL reset_spurious got=%0b/%0b want=0/0", spur0, spur1);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int nvld;
        lat = 1; max_out = 0; nvld = 0;
        req_i = 1'b1; add_i = 2'd2;
        for (int k = 0; k < 4; k++) begin
            data_i = 32'h1000_0000 + k;
            wen_i = k[0];
            cycle();
            if (obs_vld) nvld++;
            checks++;
            if (obs_gnt !== 1'b1 || obs_req !== 4'b0100) begin
                failures++; $display("FAIL b2b_grant k=%0d got=%0b/%b want=1/0100", k, obs_gnt, obs_req);
            end
            checks++;
            if (wen_o0 !== {NumOut{wen_i}} || data_o0[3] !== data_i || data_o0[0] !== data_i) begin
                failures++; $display("FAIL broadcast k=%0d got=%b/%h want=%b/%h", k, wen_o0, data_o0[3], {NumOut{wen_i}}, data_i);
            end
        end
        req_i = 1'b0; wen_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (obs_vld) nvld++;
        end
        checks++;
        if (max_out !== 1) begin
            failures++; $display("FAIL b2b_peak got=%0d want=1", max_out);
        end
        checks++;
        if (nvld !== 4 || model_out !== 0) begin
            failures++; $display("FAIL b2b_responses got=%0d left=%0d want=4 left=0", nvld, model_out);
        end
    endtask

    task automatic test_long_latency();
        int issued, start;
        int gcyc[6];
        int want[6] = '{0, 1, 2, 3, 10, 11};
        lat = 10; max_out = 0; issued = 0; start = cyc;
        add_i = 2'd1;
        for (int k = 0; k < 40 && issued < 6; k++) begin
            req_i = 1'b1;
            data_i = 32'h2000_0000 + issued;
            cycle();
            if (obs_gnt) begin
                gcyc[issued] = obs_cyc - start;
                issued++;
            end
        end
        req_i = 1'b0;
        checks++;
        if (issued !== 6) begin
            failures++; $display("FAIL long_timeout got=%0d grants want=6", issued);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (gcyc[i] !== want[i]) begin
                    failures++; $display("FAIL long_grant_cycle i=%0d got=%0d want=%0d", i, gcyc[i], want[i]);
                end
            end
        end
        checks++;
        if (max_out !== 4) begin
            failures++; $display("FAIL long_peak got=%0d want=4", max_out);
        end
        for (int k = 0; k < 40 && (model_out != 0 || legit_prev); k++) cycle();
        checks++;
        if (model_out !== 0 || busy0 !== 1'b0) begin
            failures++; $display("FAIL long_drain got=%0d want=0", model_out);
        end
    endtask

    task automatic test_bank_switch();
        int start, granted, waitbad;
        lat = 5; start = cyc; granted = -1; waitbad = 0;
        req_i = 1'b1; add_i = 2'd0;
        for (int k = 0; k < 2; k++) begin
            data_i = 32'h3000_0000 + k;
            cycle();
            checks++;
            if (obs_gnt !== 1'b1) begin
                failures++; $display("FAIL switch_first k=%0d got=%0b want=1", k, obs_gnt);
            end
        end
        add_i = 2'd3; data_i = 32'h3333_0003;
        for (int k = 0; k < 20 && granted < 0; k++) begin
            cycle();
            if (obs_gnt) begin
                granted = obs_cyc - start;
                checks++;
                if (obs_req !== 4'b1000) begin
                    failures++; $display("FAIL switch_req got=%b want=1000", obs_req);
                end
            end else if (obs_req !== 4'b0000) begin
                waitbad++;
            end
        end
        req_i = 1'b0;
        checks++;
        if (granted !== 6) begin
            failures++; $display("FAIL switch_grant_cycle got=%0d want=6", granted);
        end
        checks++;
        if (waitbad !== 0) begin
            failures++; $display("FAIL switch_stall_req got=%0d cycles want=0", waitbad);
        end
        for (int k = 0; k < 30 && (model_out != 0 || legit_prev); k++) cycle();
        checks++;
        if (model_out !== 0) begin
            failures++; $display("FAIL switch_drain got=%0d want=0", model_out);
        end
    endtask

    task automatic test_spurious();
        lat = 8; req_i = 1'b0;
        inj_bank = 2; inj_en = 1'b1;
        cycle();
        cycle();
        checks++;
        if (obs_vld !== 1'b0 || obs_out !== 0) begin
            failures++; $display("FAIL spur_idle_vld got=%0b/%0d want=0/0", obs_vld, obs_out);
        end
        cycle();
        checks++;
        if (obs_spur !== 1'b1) begin
            failures++; $display("FAIL spur_idle_pulse got=%0b want=1", obs_spur);
        end
        cycle();
        checks++;
        if (obs_spur !== 1'b0) begin
            failures++; $display("FAIL spur_idle_clear got=%0b want=0", obs_spur);
        end
        req_i = 1'b1; add_i = 2'd0; data_i = 32'h4000_0000;
        cycle();
        req_i = 1'b0;
        inj_bank = 1; inj_en = 1'b1;
        cycle();
        cycle();
        checks++;
        if (obs_vld !== 1'b0 || obs_out !== 1) begin
            failures++; $display("FAIL spur_wait_vld got=%0b/%0d want=0/1", obs_vld, obs_out);
        end
        cycle();
        checks++;
        if (obs_spur !== 1'b1 || obs_out !== 1) begin
            failures++; $display("FAIL spur_wait_pulse got=%0b/%0d want=1/1", obs_spur, obs_out);
        end
        for (int k = 0; k < 30 && (model_out != 0 || legit_prev); k++) cycle();
        checks++;
        if (model_out !== 0) begin
            failures++; $display("FAIL spur_drain got=%0d want=0", model_out);
        end
    endtask

    task automatic test_resp_reg();
        int start, v1cyc;
        bit held;
        lat = 3; start = cyc; v1cyc = -1; held = 1'b0;
        req_i = 1'b1; add_i = 2'd0; data_i = 32'hDEAD_BEEF;
        cycle();
        req_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_vld1) v1cyc = obs_cyc - start;
            if (obs_cyc - start == 5) held = (obs_vld1 === 1'b0) && (obs_rdata1 === 32'hDEAD_BEEF);
        end
        checks++;
        if (v1cyc !== 4) begin
            failures++; $display("FAIL respreg_latency got=%0d want=4", v1cyc);
        end
        checks++;
        if (!held) begin
            failures++; $display("FAIL respreg_hold got=%h want=deadbeef", rdata1);
        end
    endtask

    task automatic test_reset_mid();
        int spurcnt, vldcnt;
        lat = 10; spurcnt = 0; vldcnt = 0;
        req_i = 1'b1; add_i = 2'd1;
        for (int k = 0; k < 3; k++) begin
            data_i = 32'h5000_0000 + k;
            cycle();
        end
        req_i = 1'b0;
        cycle();
        cycle();
        checks++;
        if (out0 !== 3'd3) begin
            failures++; $display("FAIL midrst_pre got=%0d want=3", out0);
        end
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        checks++;
        if (out0 !== '0 || busy0 !== 1'b0 || vld0 !== 1'b0 || vld1 !== 1'b0) begin
            failures++; $display("FAIL midrst_clear got=%0d/%0b/%0b/%0b want=0/0/0/0", out0, busy0, vld0, vld1);
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (obs_spur) spurcnt++;
            if (obs_vld || obs_vld1) vldcnt++;
        end
        checks++;
        if (spurcnt !== 3 || vldcnt !== 0) begin
            failures++; $display("FAIL midrst_late got=%0d spur %0d vld want=3 spur 0 vld", spurcnt, vldcnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_long_latency();
        test_bank_switch();
        test_spurious();
        test_resp_reg();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
